// File: rtl/imem_load_ctrl_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave side belongs to imem_load_ctrl; the master side is the byte source / memory.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Boot loader: assembles little-endian words from a length-prefixed byte stream into imem.
// Define IMEM_LOAD_CHECKSUM_EN to require a trailing XOR checksum byte (state S_CHK).
module imem_load_ctrl #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_load_ctrl_if.slave   bus,
  output logic              core_run,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       word_cnt
);

  localparam logic [2:0] S_LEN0 = 3'd0;
  localparam logic [2:0] S_LEN1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [2:0] S_TAIL = S_CHK;
`else
  localparam logic [2:0] S_TAIL = S_DONE;
`endif

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       part_q, part_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_run_q, core_run_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        in_ready;
  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_LEN0, S_LEN1, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHK:                  in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  assign xfer      = bus.in_valid && in_ready;
  assign len_full  = {bus.in_data, len_q[7:0]};
  assign last_word = (word_cnt_q + 16'd1) == len_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    lane_d      = lane_q;
    part_d      = part_q;
    word_cnt_d  = word_cnt_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_d      = csum_q;
    if (xfer && state_q != S_CHK) csum_d = csum_q ^ bus.in_data;
`endif

    unique case (state_q)
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = bus.in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d = len_full;
          if (32'(len_full) > DEPTH) state_d = S_ERR;
          else if (len_full == 16'd0) state_d = S_TAIL;
          else state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          lane_d = lane_q + 2'd1;
          unique case (lane_q)
            2'd0: part_d[7:0]   = bus.in_data;
            2'd1: part_d[15:8]  = bus.in_data;
            2'd2: part_d[23:16] = bus.in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_wdata_d = {bus.in_data, part_q};
              // Word address equals the count of words already written.
              mem_waddr_d = word_cnt_q[ADDR_W-1:0];
              word_cnt_d  = word_cnt_q + 16'd1;
              if (last_word) state_d = S_TAIL;
            end
          endcase
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_LEN0;
          len_d       = 16'd0;
          lane_d      = 2'd0;
          part_d      = 24'd0;
          word_cnt_d  = 16'd0;
          mem_waddr_d = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_d      = 8'd0;
`endif
        end
      end
      default: state_d = S_LEN0;
    endcase

    // Release only once the final write has left the pipeline.
    core_run_d  = (state_d == S_DONE) && !mem_we_d;
    load_done_d = (state_d == S_DONE) && !mem_we_d;
    load_err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LEN0;
      len_q       <= 16'd0;
      lane_q      <= 2'd0;
      part_q      <= 24'd0;
      word_cnt_q  <= 16'd0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= 32'd0;
      core_run_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      lane_q      <= lane_d;
      part_q      <= part_d;
      word_cnt_q  <= word_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      core_run_q  <= core_run_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_run      = core_run_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign word_cnt      = word_cnt_q;

endmodule
